jk_bank_arbiter: RTL and testbench

//  Shares one bank of WIDTH JK flip-flops between N_REQ requesters.

---
 rtl/jk_arb_pkg.sv | 45 ++++
 rtl/jk_reg_bank.sv | 40 ++++
 rtl/jk_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared types, JK command encodings and the round-robin pick function for
// the jk_bank_arbiter slice.
package jk_arb_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    // Per-bit command encoding, {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Upper bound on requesters the pick function can scan
    localparam int RR_MAX_REQ = 32;

    // First set bit of valid at or after ptr, wrapping modulo n_req.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [4:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [4:0]            ptr,
        input logic [5:0]            n_req
    );
        logic [4:0] pick;
        logic       found;
        logic [5:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            // ptr < n_req and i < n_req, so one subtraction is enough to wrap
            idx = {1'b0, ptr} + 6'(i);
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            if (!found && (6'(i) < n_req) && valid[idx[4:0]]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops sharing one enable. Asynchronous active-high
// reset clears every bit.
module jk_reg_bank
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    output logic [WIDTH-1:0] o_q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic r_q;

            // One JK flop: hold / set / clear / toggle when enabled
            always_ff @(posedge clk or posedge Reset) begin
                if (Reset) begin
                    r_q <= 1'b0;
                end else if (i_en) begin
                    case ({i_j[gi], i_k[gi]})
                        JK_HOLD: r_q <= r_q;
                        JK_SET:  r_q <= 1'b1;
                        JK_CLR:  r_q <= 1'b0;
                        JK_TOG:  r_q <= ~r_q;
                        default: r_q <= r_q;
                    endcase
                end
            end

            assign o_q[gi] = r_q;
        end
    endgenerate

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK register bank between N_REQ requesters.
// A command is accepted in ARB and applied to the bank in the following
// APPLY cycle. Optional per-requester saturating grant counters are built
// when the macro JK_ARB_STATS_EN is defined.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_j,
    input  logic [N_REQ*WIDTH-1:0]     req_k,
    output logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           Qbar,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef JK_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [PTR_W-1:0]        r_grant_id;
    logic [WIDTH-1:0]        r_cmd_j;
    logic [WIDTH-1:0]        r_cmd_k;
    logic [PTR_W-1:0]        w_winner;
    logic [PTR_W-1:0]        w_ptr_next;
    logic                    w_any_valid;
    logic                    w_hs;
    logic [RR_MAX_REQ-1:0]   w_valid_ext;
    logic [WIDTH-1:0]        w_j_arr [N_REQ];
    logic [WIDTH-1:0]        w_k_arr [N_REQ];

    // Unpack the per-requester J/K vectors so the winner can select them
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_j_arr[gi] = req_j[gi*WIDTH +: WIDTH];
            assign w_k_arr[gi] = req_k[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_valid_ext = RR_MAX_REQ'(req_valid);
    assign w_any_valid = |req_valid;
    assign w_winner    = PTR_W'(rr_pick(w_valid_ext, 5'(r_rr_ptr), 6'(N_REQ)));
    assign w_ptr_next  = (w_winner == PTR_W'(N_REQ - 1)) ? '0 : (w_winner + PTR_W'(1));

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, grant and busy; ARB always accepts when anything is valid
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        busy         = 1'b0;
        w_hs         = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_any_valid) begin
                    req_ready    = N_REQ'(1) << w_winner;
                    w_hs         = 1'b1;
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy         = 1'b1;
                w_state_next = ST_ARB;
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    // Latch the winning command, remember who won, advance the pointer
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_cmd_j    <= '0;
            r_cmd_k    <= '0;
        end else if (w_hs) begin
            r_rr_ptr   <= w_ptr_next;
            r_grant_id <= w_winner;
            r_cmd_j    <= w_j_arr[w_winner];
            r_cmd_k    <= w_k_arr[w_winner];
        end
    end

    assign grant_id = r_grant_id;

    jk_reg_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .Reset (Reset),
        .i_en  (r_state == ST_APPLY),
        .i_j   (r_cmd_j),
        .i_k   (r_cmd_k),
        .o_q   (Q)
    );

    assign Qbar = ~Q;

`ifdef JK_ARB_STATS_EN
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_stats
            logic [CNT_W-1:0] r_cnt;

            // Saturating count of accepted handshakes for requester gi
            always_ff @(posedge clk or posedge Reset) begin
                if (Reset) begin
                    r_cnt <= '0;
                end else if (w_hs && (w_winner == PTR_W'(gi)) && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
`else
    // Counter width only matters when the statistics block is built
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter. The reference model tracks
// pending requests per requester, a rotating priority pointer and the bank
// value, and predicts every output from the arbitration and JK rules.
// Define JK_ARB_STATS_EN to also exercise the grant counters.
module tb_jk_bank_arbiter;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic               clk;
    logic               Reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_j;
    logic [N*W-1:0]     req_k;
    logic [W-1:0]       Q;
    logic [W-1:0]       Qbar;
    logic [1:0]         grant_id;
    logic               busy;
`ifdef JK_ARB_STATS_EN
    logic [N*CNT_W-1:0] grant_cnt;
`endif

    jk_bank_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_j     (req_j),
        .req_k     (req_k),
        .Q         (Q),
        .Qbar      (Qbar),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef JK_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold valid until accepted
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_hold
            assert property (@(posedge clk) disable iff (Reset)
                (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi])
                else $error("FAIL valid_hold: requester %0d withdrew valid", gi);
        end
    endgenerate

    // Requester side
    logic [N-1:0] pend;
    logic [W-1:0] pj [N];
    logic [W-1:0] pk [N];

    // Reference model
    logic [W-1:0] m_q;
    logic [W-1:0] m_cj;
    logic [W-1:0] m_ck;
    bit           m_apply;
    int           m_gid;
    int           m_ptr;
    int           m_cnt [N];
    logic [N-1:0] exp_ready;

    int g_dut[$];
    int n_checks;
    int n_errors;
    int n_txn;

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Bank update from the command masks: set, clear, then toggle
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                             input logic [W-1:0] j,
                                             input logic [W-1:0] k);
        logic [W-1:0] set_m, clr_m, tog_m;
        set_m = j & ~k;
        clr_m = ~j & k;
        tog_m = j & k;
        return ((q | set_m) & ~clr_m) ^ tog_m;
    endfunction

    task automatic model_reset();
        m_q     = '0;
        m_cj    = '0;
        m_ck    = '0;
        m_apply = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        for (int r = 0; r < N; r++) m_cnt[r] = 0;
    endtask

    task automatic post(input int r, input logic [W-1:0] j, input logic [W-1:0] k);
        pend[r] = 1'b1;
        pj[r]   = j;
        pk[r]   = k;
    endtask

    task automatic drive();
        req_valid = pend;
        for (int r = 0; r < N; r++) begin
            req_j[r*W +: W] = pj[r];
            req_k[r*W +: W] = pk[r];
        end
    endtask

    // mode 0: no new requests, 1: random new requests, 2: keep all pending
    task automatic prepare(input int mode);
        int w;
        for (int r = 0; r < N; r++) begin
            if (!pend[r] && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)))
                post(r, W'($urandom), W'($urandom));
        end
        drive();
        #1;
        w = pick_winner();
        exp_ready = '0;
        if (!m_apply && w >= 0) exp_ready[w] = 1'b1;
    endtask

    // Advance the model across one rising edge and move the DUT with it
    task automatic advance();
        int w;
        bit acc;
        w   = pick_winner();
        acc = 1'b0;
        if (m_apply) begin
            m_q     = jk_next(m_q, m_cj, m_ck);
            m_apply = 1'b0;
        end else if (w >= 0) begin
            m_cj    = pj[w];
            m_ck    = pk[w];
            m_gid   = w;
            m_ptr   = (w + 1) % N;
            pend[w] = 1'b0;
            if (m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
            m_apply = 1'b1;
            acc     = 1'b1;
            n_txn++;
            $display("txn %0d t=%0t requester=%0d J=%h K=%h", n_txn, $time, w, m_cj, m_ck);
        end
        @(posedge clk);
        @(negedge clk);
        if (acc) g_dut.push_back(int'(grant_id));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        pend  = '0;
        drive();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        g_dut.delete();
    endtask

    task automatic test_reset();
        do_reset();
        prepare(0);
        n_checks++; if (Q !== 8'h00) begin n_errors++; $display("FAIL reset_q: got %h expected 00", Q); end
        n_checks++; if (Qbar !== 8'hFF) begin n_errors++; $display("FAIL reset_qbar: got %h expected ff", Qbar); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
`ifdef JK_ARB_STATS_EN
        n_checks++; if (grant_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt: got %h expected 0", grant_cnt); end
`endif
        // Accept a set-all command, then reset while it waits in APPLY
        post(0, 8'hFF, 8'h00);
        prepare(0);
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midapply_ready: got %b expected 0001", req_ready); end
        advance();
        prepare(0);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midapply_busy: got %b expected 1", busy); end
        #1 Reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (Q !== 8'h00) begin n_errors++; $display("FAIL midapply_q_async: got %h expected 00", Q); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midapply_busy_async: got %b expected 0", busy); end
        #1 Reset = 1'b0;
        advance();
        n_checks++; if (Q !== 8'h00) begin n_errors++; $display("FAIL midapply_dropped: got %h expected 00", Q); end
        // Pointer back at 0: all valid must grant requester 0
        for (int r = 0; r < N; r++) post(r, 8'h00, 8'h00);
        prepare(0);
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midapply_ptr: got %b expected 0001", req_ready); end
    endtask

    task automatic test_truth_table();
        do_reset();
        post(1, 8'hF0, 8'h0F);
        prepare(0); advance();
        prepare(0); advance();
        n_checks++; if (Q !== 8'hF0) begin n_errors++; $display("FAIL tt_first: got %h expected f0", Q); end
        post(1, 8'hCC, 8'hAA);
        prepare(0); advance();
        prepare(0); advance();
        // hold 0x11, set 0x44, clear 0x22, toggle 0x88 applied to 0xF0
        n_checks++; if (Q !== 8'h5C) begin n_errors++; $display("FAIL tt_mixed: got %h expected 5c", Q); end
        n_checks++; if (Q !== m_q) begin n_errors++; $display("FAIL tt_model: got %h expected %h", Q, m_q); end
        n_checks++; if (Qbar !== 8'hA3) begin n_errors++; $display("FAIL tt_qbar: got %h expected a3", Qbar); end
    endtask

    task automatic test_round_robin();
        int cyc;
        do_reset();
        cyc = 0;
        while (g_dut.size() < 8 && cyc < 40) begin
            prepare(2);
            n_checks++; if ($countones(req_ready) > 1) begin n_errors++; $display("FAIL rr_onehot: got %b expected at most one bit", req_ready); end
            n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rr_ready: got %b expected %b", req_ready, exp_ready); end
            advance();
            cyc++;
        end
        n_checks++;
        if (g_dut.size() < 8) begin
            n_errors++; $display("FAIL rr_timeout: got %0d grants expected 8", g_dut.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (g_dut[i] != i % 4) begin n_errors++; $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, g_dut[i], i % 4); end
            end
        end
    endtask

    task automatic test_pointer_skip();
        int cyc;
        do_reset();
        post(1, 8'h01, 8'h00);
        prepare(0); advance();
        prepare(0); advance();
        g_dut.delete();
        post(0, 8'h02, 8'h00);
        post(3, 8'h04, 8'h00);
        cyc = 0;
        while (g_dut.size() < 2 && cyc < 10) begin
            prepare(0); advance(); cyc++;
        end
        n_checks++;
        if (g_dut.size() < 2) begin
            n_errors++; $display("FAIL skip_timeout: got %0d grants expected 2", g_dut.size());
        end else begin
            n_checks++; if (g_dut[0] != 3) begin n_errors++; $display("FAIL skip_first: got %0d expected 3", g_dut[0]); end
            n_checks++; if (g_dut[1] != 0) begin n_errors++; $display("FAIL skip_second: got %0d expected 0", g_dut[1]); end
        end
    endtask

    task automatic test_timing();
        do_reset();
        post(2, 8'h0F, 8'h00);
        prepare(0);
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL tm_ready: got %b expected 0100", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tm_busy_pre: got %b expected 0", busy); end
        advance();
        // After edge T: bank unchanged, APPLY with a new request waiting
        post(3, 8'hF0, 8'h00);
        prepare(0);
        n_checks++; if (Q !== 8'h00) begin n_errors++; $display("FAIL tm_q_at_T: got %h expected 00", Q); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL tm_busy: got %b expected 1", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL tm_ready_apply: got %b expected 0000", req_ready); end
        n_checks++; if (grant_id !== 2'd2) begin n_errors++; $display("FAIL tm_gid: got %0d expected 2", grant_id); end
        advance();
        prepare(0);
        n_checks++; if (Q !== 8'h0F) begin n_errors++; $display("FAIL tm_q_at_T1: got %h expected 0f", Q); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tm_busy_one: got %b expected 0", busy); end
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL tm_next_ready: got %b expected 1000", req_ready); end
        advance();
        prepare(0); advance();
        n_checks++; if (Q !== 8'hFF) begin n_errors++; $display("FAIL tm_q_second: got %h expected ff", Q); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 150; c++) begin
            prepare(1);
            n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, req_ready, exp_ready); end
            n_checks++; if (busy !== m_apply) begin n_errors++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, m_apply); end
            n_checks++; if (Q !== m_q) begin n_errors++; $display("FAIL rnd_q c=%0d: got %h expected %h", c, Q, m_q); end
            n_checks++; if (Qbar !== ~m_q) begin n_errors++; $display("FAIL rnd_qbar c=%0d: got %h expected %h", c, Qbar, ~m_q); end
            n_checks++; if (grant_id !== 2'(m_gid)) begin n_errors++; $display("FAIL rnd_gid c=%0d: got %0d expected %0d", c, grant_id, m_gid); end
`ifdef JK_ARB_STATS_EN
            for (int r = 0; r < N; r++) begin
                n_checks++; if (grant_cnt[r*CNT_W +: CNT_W] !== CNT_W'(m_cnt[r])) begin n_errors++; $display("FAIL rnd_cnt%0d c=%0d: got %0d expected %0d", r, c, grant_cnt[r*CNT_W +: CNT_W], m_cnt[r]); end
            end
`endif
            advance();
        end
    endtask

`ifdef JK_ARB_STATS_EN
    task automatic test_stats();
        int cyc;
        do_reset();
        cyc = 0;
        while (g_dut.size() < 5 && cyc < 30) begin
            if (!pend[2]) post(2, W'($urandom), W'($urandom));
            prepare(0); advance(); cyc++;
        end
        prepare(0); advance();
        n_checks++; if (g_dut.size() < 5) begin n_errors++; $display("FAIL st_timeout: got %0d grants expected 5", g_dut.size()); end
        for (int r = 0; r < N; r++) begin
            n_checks++;
            if (grant_cnt[r*CNT_W +: CNT_W] !== ((r == 2) ? 2'd3 : 2'd0)) begin
                n_errors++; $display("FAIL st_cnt%0d: got %0d expected %0d", r, grant_cnt[r*CNT_W +: CNT_W], (r == 2) ? 3 : 0);
            end
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_txn     = 0;
        Reset     = 1'b1;
        pend      = '0;
        req_valid = '0;
        req_j     = '0;
        req_k     = '0;
        for (int r = 0; r < N; r++) begin
            pj[r] = '0;
            pk[r] = '0;
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_truth_table();
        test_round_robin();
        test_pointer_skip();
        test_timing();
        test_random();
`ifdef JK_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
